// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access -- RV32I memory-access stage.
//
// Takes the effective address (alu_result) and store data (reg2_data) from
// the execute stage, runs one request/acknowledge transaction to data memory
// per load or store, and stalls the pipeline until that transaction is done.
// Load data is byte-aligned and sign/zero-extended before going to
// write-back. Misaligned accesses are flagged and never issued. An access
// that is not acknowledged within TIMEOUT_CYCLES BUSY cycles is aborted
// with a bus_error pulse.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   ex_valid             instruction/operand inputs valid this cycle
//   instruction          current instruction (opcode [6:0], funct3 [14:12])
//   alu_result           effective byte address
//   reg2_data            store source data
//   mem_req/we/addr/wdata/wstrb   registered request to data memory
//   mem_ack, mem_rdata   memory completion and read word
//   wb_memory_read_data  extended load result (registered)
//   read_valid           wb_memory_read_data is fresh this cycle
//   stall_flag           hold PC, IF/ID and EX (combinational)
//   misaligned_flag      current load/store is misaligned (combinational)
//   bus_error            one-cycle pulse when an access times out
// ---------------------------------------------------------------------------
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] instruction,
    input  logic [31:0] alu_result,
    input  logic [31:0] reg2_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] wb_memory_read_data,
    output logic        read_valid,
    output logic        stall_flag,
    output logic        misaligned_flag,
    output logic        bus_error
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    // Abort on the last permitted BUSY cycle without an ack, so mem_req is
    // high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic        req_q, we_q, rvalid_q, berr_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [7:0]  cnt_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load, is_store, mem_op, misaligned, accept;
    logic [31:0] wdata_d;
    logic [3:0]  wstrb_d;
    logic        unused_instr_bits;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign unused_instr_bits = ^{instruction[31:15], instruction[11:7]};

    // Byte/halfword select at the latched offset, then extend per funct3.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = 32'(b);              // LB, sign-extended
            3'b001:  r = 32'(h);              // LH, sign-extended
            3'b100:  r = {24'd0, b};          // LBU
            3'b101:  r = {16'd0, h};          // LHU
            default: r = word;                // LW
        endcase
        return r;
    endfunction

    always_comb begin
        is_load  = (opcode == OP_LOAD) &&
                   (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                    funct3 == 3'b100 || funct3 == 3'b101);
        is_store = (opcode == OP_STORE) &&
                   (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
        mem_op   = is_load || is_store;
        // funct3[1:0] encodes access size for both loads and stores.
        misaligned = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                     ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
        accept   = ex_valid && mem_op && !misaligned;

        wdata_d = reg2_data;
        wstrb_d = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata_d = {4{reg2_data[7:0]}};
                wstrb_d = 4'b0001 << alu_result[1:0];
            end
            2'b01: begin
                wdata_d = {2{reg2_data[15:0]}};
                wstrb_d = 4'b0011 << alu_result[1:0];
            end
            default: ;
        endcase
        if (!is_store) begin
            wstrb_d = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            berr_q   <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            cnt_q    <= '0;
        end else begin
            rvalid_q <= 1'b0;
            berr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_q    <= 1'b1;
                        we_q     <= is_store;
                        addr_q   <= {alu_result[31:2], 2'b00};
                        wdata_q  <= wdata_d;
                        wstrb_q  <= wstrb_d;
                        funct3_q <= funct3;
                        off_q    <= alu_result[1:0];
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (mem_ack) begin
                        req_q   <= 1'b0;
                        if (!we_q) begin
                            rdata_q  <= load_extend(funct3_q, off_q, mem_rdata);
                            rvalid_q <= 1'b1;
                        end
                        state_q <= DONE;
                    end else if (cnt_q == TO_LAST) begin
                        req_q    <= 1'b0;
                        berr_q   <= 1'b1;
                        rdata_q  <= '0;
                        rvalid_q <= !we_q;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req             = req_q;
    assign mem_we              = we_q;
    assign mem_addr            = addr_q;
    assign mem_wdata           = wdata_q;
    assign mem_wstrb           = wstrb_q;
    assign wb_memory_read_data = rdata_q;
    assign read_valid          = rvalid_q;
    assign bus_error           = berr_q;
    assign stall_flag          = ((state_q == IDLE) && accept) || (state_q == BUSY);
    assign misaligned_flag     = ex_valid && mem_op && misaligned;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] instruction, alu_result, reg2_data;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] wb_memory_read_data;
    logic        read_valid, stall_flag, misaligned_flag, bus_error;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .instruction(instruction),
        .alu_result(alu_result), .reg2_data(reg2_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_memory_read_data(wb_memory_read_data), .read_valid(read_valid),
        .stall_flag(stall_flag), .misaligned_flag(misaligned_flag),
        .bus_error(bus_error)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
        return {17'd0, f3, 5'd0, op};
    endfunction

    // Reference extraction written as an explicit case on the offset.
    function automatic logic [31:0] ref_byte(input logic [31:0] w, input logic [1:0] off,
                                             input bit sgn);
        logic [7:0] b;
        case (off)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        return (sgn && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
    endfunction

    // Scoreboard: every read_valid pops one expected load result.
    always @(negedge clk) begin
        if (read_valid) begin
            if (sb.size() == 0) chk("rv_unexpected", 32'd1, 32'd0);
            else chk("rdata", wb_memory_read_data, sb.pop_front());
        end
    end

    task automatic access(input logic [31:0] instr, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] rdata,
                          input int delay, input bit to,
                          input logic [31:0] exp_d, input logic [31:0] exp_wd,
                          input logic [3:0] exp_strb);
        bit is_load;
        int done_c, stalls, reqs;
        is_load = (instr[6:0] == 7'b0000011);
        done_c  = to ? (1 + TO) : (2 + delay);
        stalls  = 0;
        reqs    = 0;
        ex_valid = 1'b1; instruction = instr; alu_result = addr; reg2_data = rs2;
        mem_rdata = rdata;
        if (is_load) sb.push_back(exp_d);
        for (int c = 0; c <= done_c; c++) begin
            mem_ack = !to && (c == 1 + delay);
            @(negedge clk);
            if (stall_flag) stalls++;
            if (mem_req) begin
                reqs++;
                chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
                chk("mem_we", 32'(mem_we), 32'(!is_load));
                chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_strb));
                if (!is_load) chk("mem_wdata", mem_wdata, exp_wd);
            end
            if (c == done_c) chk("bus_error", 32'(bus_error), 32'(to));
            @(posedge clk); #1;
        end
        ex_valid = 1'b0;
        mem_ack  = 1'b0;
        chk("stall_cycles", 32'(stalls), 32'(done_c));
        chk("req_cycles", 32'(reqs), 32'(done_c - 1));
    endtask

    initial begin
        int rv_seen;
        logic [31:0] w;
        rst = 1'b1; ex_valid = 1'b0; instruction = '0; alu_result = '0;
        reg2_data = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_wb", wb_memory_read_data, 32'd0);
        chk("rst_rv", 32'(read_valid), 32'd0);
        chk("rst_berr", 32'(bus_error), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Loads and extension
        access(mk(3'b010, 7'b0000011), 32'h100, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 4'b0000);
        access(mk(3'b000, 7'b0000011), 32'h203, 0, 32'h80FF1234, 0, 0, 32'hFFFFFF80, 0, 4'b0000);
        access(mk(3'b100, 7'b0000011), 32'h203, 0, 32'h80FF1234, 1, 0, 32'h00000080, 0, 4'b0000);
        access(mk(3'b101, 7'b0000011), 32'h202, 0, 32'h80FF1234, 0, 0, 32'h000080FF, 0, 4'b0000);
        access(mk(3'b001, 7'b0000011), 32'h202, 0, 32'h80FF1234, 2, 0, 32'hFFFF80FF, 0, 4'b0000);
        access(mk(3'b001, 7'b0000011), 32'h200, 0, 32'h80FF9234, 0, 0, 32'hFFFF9234, 0, 4'b0000);
        for (int off = 0; off < 4; off++) begin
            w = $urandom;
            access(mk(3'b000, 7'b0000011), 32'h500 + off, 0, w, off % 3, 0,
                   ref_byte(w, 2'(off), 1), 0, 4'b0000);
            access(mk(3'b100, 7'b0000011), 32'h500 + off, 0, w, 0, 0,
                   ref_byte(w, 2'(off), 0), 0, 4'b0000);
        end

        // Stores; SH with ack delayed to the last permitted BUSY cycle
        access(mk(3'b001, 7'b0100011), 32'h106, 32'h0000ABCD, 0, 3, 0, 0, 32'hABCDABCD, 4'b1100);
        access(mk(3'b000, 7'b0100011), 32'h103, 32'h12345677, 0, 0, 0, 0, 32'h77777777, 4'b1000);
        access(mk(3'b010, 7'b0100011), 32'h208, 32'hCAFEF00D, 0, 1, 0, 0, 32'hCAFEF00D, 4'b1111);

        // Misaligned LW: flagged, not issued, no stall
        ex_valid = 1'b1; instruction = mk(3'b010, 7'b0000011); alu_result = 32'h102;
        @(negedge clk);
        chk("mis_flag", 32'(misaligned_flag), 32'd1);
        chk("mis_stall", 32'(stall_flag), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mis_req", 32'(mem_req), 32'd0);
        // Misaligned SH at odd address
        instruction = mk(3'b001, 7'b0100011); alu_result = 32'h105;
        @(negedge clk);
        chk("mis_sh_flag", 32'(misaligned_flag), 32'd1);
        // Non-memory ops: ALU op and unsupported load funct3
        instruction = mk(3'b000, 7'b0110011); alu_result = 32'h102;
        @(negedge clk);
        chk("alu_mis", 32'(misaligned_flag), 32'd0);
        chk("alu_stall", 32'(stall_flag), 32'd0);
        instruction = mk(3'b011, 7'b0000011); alu_result = 32'h100;
        @(negedge clk);
        chk("f3_011_stall", 32'(stall_flag), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("f3_011_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0;

        // Timeout: mem_req high TO cycles, bus_error pulse, data 0
        access(mk(3'b010, 7'b0000011), 32'h300, 0, 32'h11111111, 0, 1, 32'h0, 0, 4'b0000);
        @(negedge clk);
        chk("berr_pulse_end", 32'(bus_error), 32'd0);
        @(posedge clk); #1;

        // Reset during the 2nd BUSY cycle, then a late ack
        ex_valid = 1'b1; instruction = mk(3'b010, 7'b0000011); alu_result = 32'h400;
        mem_rdata = 32'h55AA55AA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ex_valid = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        chk("rst_busy_req", 32'(mem_req), 32'd0);
        chk("rst_busy_stall", 32'(stall_flag), 32'd0);
        rv_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (read_valid) rv_seen++;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("late_ack_rv", 32'(rv_seen), 32'd0);
        chk("late_ack_req", 32'(mem_req), 32'd0);

        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
